// File: rtl/buck_pwm_ctrl.sv
// Fixed-frequency buck PWM: bang-bang duty regulation from a voltage comparator and
// cycle-by-cycle overcurrent cut-off. Define BUCK_PWM_SOFTSTART_EN to add a soft-start ramp.
module buck_pwm_ctrl #(
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned PERIOD    = 1000,
  parameter int unsigned DUTY_INIT = 500,
  parameter int unsigned DUTY_MIN  = 0,
  parameter int unsigned DUTY_MAX  = 900,
  parameter int unsigned STEP      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fb_high,
  input  logic             oc_trip,
  output logic             ctrl,
  output logic [CNT_W-1:0] duty,
  output logic             period_start,
  output logic [1:0]       state
);

  localparam int unsigned EXT_W = CNT_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SOFT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] DUTY_INIT_C = CNT_W'(DUTY_INIT);
  localparam logic [CNT_W-1:0] DUTY_MIN_C  = CNT_W'(DUTY_MIN);
  localparam logic [CNT_W-1:0] DUTY_MAX_C  = CNT_W'(DUTY_MAX);
  localparam logic [CNT_W-1:0] STEP_C      = CNT_W'(STEP);
  localparam logic [EXT_W-1:0] STEP_X      = EXT_W'(STEP);
  localparam logic [EXT_W-1:0] DEC_FLOOR_X = EXT_W'(DUTY_MIN + STEP);

  logic             fb_meta_q, fb_s_q, oc_meta_q, oc_s_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             term_q, term_d;
  logic [CNT_W-1:0] duty_reg_q, duty_reg_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             ctrl_q, ctrl_d;
  logic             period_start_q, period_start_d;

  logic             wrap, starting;
  logic [CNT_W-1:0] lim_wrap, lim_start;
  logic [EXT_W-1:0] inc_x;
  logic [CNT_W-1:0] duty_inc, duty_dec;
  logic [1:0]       start_state;

`ifdef BUCK_PWM_SOFTSTART_EN
  logic [CNT_W-1:0] lim_q, lim_d;
  logic [EXT_W-1:0] lim_step_x;

  // Ramp limit grows one step per wrap, saturating at the run limit.
  always_comb begin
    lim_step_x  = {1'b0, lim_q} + STEP_X;
    lim_wrap    = (lim_step_x >= {1'b0, DUTY_MAX_C}) ? DUTY_MAX_C : lim_step_x[CNT_W-1:0];
    lim_start   = '0;
    start_state = ST_SOFT;
    lim_d       = lim_q;
    if (starting) lim_d = lim_start;
    else if (wrap) lim_d = lim_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lim_q <= '0;
    else        lim_q <= lim_d;
  end
`else
  always_comb begin
    lim_wrap    = DUTY_MAX_C;
    lim_start   = DUTY_MAX_C;
    start_state = ST_RUN;
  end
`endif

  // Two-flop synchronizers for the asynchronous comparators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_meta_q <= 1'b0;
      fb_s_q    <= 1'b0;
      oc_meta_q <= 1'b0;
      oc_s_q    <= 1'b0;
    end else begin
      fb_meta_q <= fb_high;
      fb_s_q    <= fb_meta_q;
      oc_meta_q <= oc_trip;
      oc_s_q    <= oc_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign wrap = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = start_state;
        ST_SOFT: if (wrap && (lim_wrap == DUTY_MAX_C)) state_d = ST_RUN;
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign starting = (state_q == ST_IDLE) && (state_d != ST_IDLE);

  // Saturating duty steps, computed one bit wider so they cannot wrap.
  always_comb begin
    inc_x    = {1'b0, duty_reg_q} + STEP_X;
    duty_inc = (inc_x > {1'b0, lim_wrap}) ? lim_wrap : inc_x[CNT_W-1:0];
    duty_dec = ({1'b0, duty_reg_q} < DEC_FLOOR_X) ? DUTY_MIN_C : (duty_reg_q - STEP_C);
  end

  // Period counter, duty regulation, shadow load and overcurrent latch.
  always_comb begin
    cnt_d      = cnt_q;
    duty_reg_d = duty_reg_q;
    duty_d     = duty_q;
    term_d     = term_q;
    if (state_d == ST_IDLE) begin
      cnt_d = '0;
    end else if (starting) begin
      cnt_d      = '0;
      duty_reg_d = (DUTY_INIT_C < lim_start) ? DUTY_INIT_C : lim_start;
    end else if (wrap) begin
      cnt_d      = '0;
      duty_reg_d = fb_s_q ? duty_dec : duty_inc;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if ((state_d != ST_IDLE) && (cnt_d == '0)) duty_d = duty_reg_d;
    if ((state_d == ST_IDLE) || starting) begin
      term_d = 1'b0;
    end else begin
      term_d = ((cnt_d == '0) ? 1'b0 : term_q) | (oc_s_q & (cnt_d < duty_d));
    end
  end

  // Outputs are computed from next-cycle values so they align with cnt.
  always_comb begin
    ctrl_d         = (state_d != ST_IDLE) && (cnt_d < duty_d) && !term_d;
    period_start_d = (state_d != ST_IDLE) && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      duty_reg_q     <= '0;
      duty_q         <= '0;
      term_q         <= 1'b0;
      ctrl_q         <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      duty_reg_q     <= duty_reg_d;
      duty_q         <= duty_d;
      term_q         <= term_d;
      ctrl_q         <= ctrl_d;
      period_start_q <= period_start_d;
    end
  end

  assign ctrl         = ctrl_q;
  assign duty         = duty_q;
  assign period_start = period_start_q;
  assign state        = state_q;

endmodule

// File: tb/tb_buck_pwm_ctrl.sv
// Directed + randomized bench for buck_pwm_ctrl with a per-period behavioural model.
// Uses reduced parameters so saturation and clamp corners are reached quickly.
module tb_buck_pwm_ctrl;

  localparam int CW    = 8;
  localparam int P     = 60;
  localparam int DINIT = 31;
  localparam int DMIN  = 0;
  localparam int DMAX  = 50;
  localparam int STP   = 4;

  logic          clk, rst_n, en, fb_high, oc_trip;
  logic          ctrl, period_start;
  logic [CW-1:0] duty;
  logic [1:0]    state;

  int n_checks = 0;
  int n_err    = 0;

  int exp_duty, exp_lim, exp_state;

  buck_pwm_ctrl #(
    .CNT_W(CW), .PERIOD(P), .DUTY_INIT(DINIT),
    .DUTY_MIN(DMIN), .DUTY_MAX(DMAX), .STEP(STP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fb_high(fb_high), .oc_trip(oc_trip),
    .ctrl(ctrl), .duty(duty), .period_start(period_start), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start-up values: limit is the soft-start floor or the run ceiling.
  task automatic model_start();
`ifdef BUCK_PWM_SOFTSTART_EN
    exp_state = 1;
    exp_lim   = 0;
`else
    exp_state = 2;
    exp_lim   = DMAX;
`endif
    exp_duty = (DINIT < exp_lim) ? DINIT : exp_lim;
  endtask

  // End-of-period duty regulation from the comparator level held during the period.
  task automatic model_wrap(input bit fb);
    if (exp_state == 1) exp_lim = (exp_lim + STP > DMAX) ? DMAX : exp_lim + STP;
    if (fb) exp_duty = (exp_duty - STP < DMIN) ? DMIN : exp_duty - STP;
    else    exp_duty = (exp_duty + STP > exp_lim) ? exp_lim : exp_duty + STP;
    if (exp_state == 1 && exp_lim == DMAX) exp_state = 2;
  endtask

  // Runs one full period from its first cycle; ctrl is expected high for
  // cnt < duty and cnt < cut, where cut is the first cnt blanked by overcurrent.
  task automatic run_period(input string tag, input bit fb, input int oc_on,
                            input int oc_off, input int cut);
    int ctrl_bad, ps_bad, duty_bad, st_bad, highs, exp_highs;
    ctrl_bad = 0; ps_bad = 0; duty_bad = 0; st_bad = 0; highs = 0; exp_highs = 0;
    for (int i = 0; i < P; i++) begin
      bit exp_c;
      exp_c = (i < exp_duty) && (i < cut);
      if (ctrl !== exp_c) ctrl_bad++;
      if (ctrl === 1'b1) highs++;
      if (exp_c) exp_highs++;
      if (period_start !== (i == 0)) ps_bad++;
      if (duty !== CW'(exp_duty)) duty_bad++;
      if (state !== 2'(exp_state)) st_bad++;
      if (i == P / 2) fb_high = fb;
      if (i == oc_on) oc_trip = 1'b1;
      if (i == oc_off) oc_trip = 1'b0;
      @(negedge clk);
    end
    chk({tag, " on_cycles"}, highs, exp_highs);
    chk({tag, " ctrl_pattern_errs"}, ctrl_bad, 0);
    chk({tag, " period_start_errs"}, ps_bad, 0);
    chk({tag, " duty_errs"}, duty_bad, 0);
    chk({tag, " state_errs"}, st_bad, 0);
    model_wrap(fb);
  endtask

  initial begin
    int fbr;
    rst_n = 1'b0; en = 1'b0; fb_high = 1'b0; oc_trip = 1'b0;
    exp_duty = 0; exp_lim = 0; exp_state = 0;
    repeat (3) @(negedge clk);
    chk("reset ctrl", ctrl, 0);
    chk("reset duty", duty, 0);
    chk("reset period_start", period_start, 0);
    chk("reset state", state, 0);

    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle ctrl", ctrl, 0);
    chk("idle state", state, 0);
    chk("idle period_start", period_start, 0);

    en = 1'b1;
    @(negedge clk);
    model_start();
    chk("start state", state, exp_state);
    chk("start duty", duty, exp_duty);
    chk("start period_start", period_start, 1);

    for (int k = 0; k < 10; k++) begin
      fbr = $urandom_range(0, 1);
      run_period("rand", fbr[0], -1, -1, P);
    end

    for (int k = 0; k < 14; k++) run_period("ramp_up", 1'b0, -1, -1, P);
    chk("sat_max duty", duty, DMAX);

    for (int k = 0; k < 15; k++) run_period("ramp_down", 1'b1, -1, -1, P);
    chk("sat_min duty", duty, DMIN);
    run_period("zero_duty", 1'b0, -1, -1, P);

    for (int k = 0; k < 14; k++) run_period("recover", 1'b0, -1, -1, P);

    run_period("oc_pulse", 1'b0, 20, 23, 23);
    run_period("oc_after", 1'b0, -1, -1, P);
    run_period("oc_pre_wrap", 1'b0, P - 3, -1, P);
    run_period("oc_at_start", 1'b0, -1, 5, 0);
    run_period("oc_cleared", 1'b0, -1, -1, P);

    repeat (10) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("en_drop ctrl", ctrl, 0);
    chk("en_drop state", state, 0);
    chk("en_drop period_start", period_start, 0);
    repeat (3) @(negedge clk);
    chk("en_low ctrl", ctrl, 0);
    en = 1'b1;
    @(negedge clk);
    model_start();
    chk("restart period_start", period_start, 1);
    chk("restart duty", duty, exp_duty);
    chk("restart state", state, exp_state);
    run_period("restart", 1'b0, -1, -1, P);

    en = 1'b0;
    @(negedge clk);
    chk("blip idle state", state, 0);
    chk("blip idle ctrl", ctrl, 0);
    en = 1'b1;
    @(negedge clk);
    model_start();
    chk("blip restart state", state, exp_state);
    chk("blip restart period_start", period_start, 1);
    run_period("blip", 1'b1, -1, -1, P);

    repeat (10) @(negedge clk);
    if (exp_duty > 10) chk("pre_reset ctrl", ctrl, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset ctrl", ctrl, 0);
    chk("async_reset state", state, 0);
    chk("async_reset duty", duty, 0);
    chk("async_reset period_start", period_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_start();
    chk("post_reset state", state, exp_state);
    chk("post_reset duty", duty, exp_duty);
    chk("post_reset period_start", period_start, 1);
    run_period("post_reset", 1'b0, -1, -1, P);
    run_period("post_reset2", 1'b0, -1, -1, P);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
